ram8bit_tester: RTL and testbench
=================================

RAM8BIT_TESTER -- requirements
Module: ram8bit_tester

Interface
REQ-001 Parameter RD_LAT, default 1: cycles from the rd_co cycle until ram_out is valid; legal range 1..4.
REQ-002 Port clk  input  1  single clock; all logic on the rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port start  input  1  one-cycle pulse that begins a test run.
REQ-005 Port abort  input  1  terminates a run in progress.
REQ-006 Port wr_co  output  1  RAM write strobe.
REQ-007 Port rd_co  output  1  RAM read strobe.
REQ-008 Port data  output  8  RAM write data.
REQ-009 Port ram_out  input  8  RAM read data.
REQ-010 Port busy  output  1  high while a run is in progress.
REQ-011 Port done  output  1  high once a run has ended; held until the next start or reset.
REQ-012 Port pass  output  1  valid when done=1; 1 means no mismatch and no abort.
REQ-013 Port err_cnt  output  8  count of mismatches, saturating at 255.
REQ-014 Port fail_pat  output  8  pattern of the first mismatch; 0x00 if there was none.

Function
REQ-015 The FSM states SHALL be IDLE, WR, RD, WAIT, CMP and DONE; all outputs SHALL be registered.
REQ-016 start sampled in IDLE or DONE SHALL clear err_cnt, fail_pat, pass and done, select pattern 0 and enter WR; start SHALL be ignored in every other state.
REQ-017 WR: wr_co=1 and data=current pattern for exactly one cycle, then enter RD.
REQ-018 RD: rd_co=1 for exactly one cycle, then enter WAIT.
REQ-019 WAIT: hold for RD_LAT cycles, then enter CMP.
REQ-020 CMP: compare ram_out with the pattern. On mismatch, increment err_cnt, saturating at 255. On the first mismatch only, record the pattern in fail_pat.
REQ-021 After CMP, advance to the next pattern and enter WR; after the last pattern, enter DONE.
REQ-022 Each pattern SHALL take 3+RD_LAT cycles.
REQ-023 The base pattern order SHALL be 0x00, 0xFF, 0x55, 0xAA.
REQ-024 wr_co and rd_co SHALL never be high in the same cycle, and SHALL both be 0 in IDLE, WAIT, CMP and DONE.
REQ-025 data SHALL hold its last driven value outside WR.
REQ-026 busy=1 in WR, RD, WAIT and CMP only.
REQ-027 DONE: done=1, and pass=1 only if err_cnt==0 and the run was not aborted.
REQ-028 abort sampled in WR, RD, WAIT or CMP SHALL enter DONE on the next edge with pass=0 and no further strobes.
REQ-029 abort SHALL take priority over a CMP result in the same cycle; that comparison SHALL not be counted.
REQ-030 abort sampled in IDLE or DONE SHALL be ignored.

Reset
REQ-031 rst SHALL force IDLE with wr_co=0, rd_co=0, data=0x00, busy=0, done=0, pass=0, err_cnt=0 and fail_pat=0x00 on the next edge.
REQ-032 rst SHALL take priority over start and abort.
REQ-033 rst asserted mid-run SHALL discard the run with no further strobes; a run then requires a new start.

Configuration
REQ-034 With RAM8BIT_TESTER_WALK_EN defined, the pattern list SHALL be extended after 0xAA with walking ones 0x01, 0x02, 0x04 ... 0x80, giving 12 patterns.
REQ-035 Without RAM8BIT_TESTER_WALK_EN, only the 4 base patterns SHALL be used, and the pattern index SHALL be 2 bits wide.

Structure
REQ-036 Package ram8bit_pkg SHALL hold the FSM state typedef, the base pattern constants and the pattern count constants.
REQ-037 Sub-module ram8bit_pat_rom SHALL map pattern index to pattern value, combinationally.

Verification
REQ-038 RD_LAT=1, ideal RAM model, start pulsed at edge E0: done=1 and pass=1 at E16, exactly 4 wr_co and 4 rd_co pulses, err_cnt=0.
REQ-039 RAM model with bit 0 stuck at 0: err_cnt=2 (for 0xFF and 0x55), fail_pat=0xFF, pass=0.
REQ-040 abort during the RD cycle of pattern 0x55: done=1 on the next edge, pass=0, no further strobes, err_cnt unchanged.
REQ-041 rst pulsed during WAIT: all outputs at reset values on the next edge; a subsequent start performs a complete run.
REQ-042 RAM8BIT_TESTER_WALK_EN defined with RD_LAT=2: done at start+60 cycles; 12 writes in the order 00, FF, 55, AA, 01 .. 80; wr_co and rd_co never both high.
REQ-043 RAM model returning the inverted write data, with RD_LAT=1 and RAM8BIT_TESTER_WALK_EN defined: err_cnt=12, fail_pat=0x00; start pulsed while busy has no effect.

Source files
------------

// File: rtl/ram8bit_pkg.sv
// rtl/ram8bit_pkg.sv - shared state encoding, pattern constants and counts for the RAM tester (RAM8BIT_TESTER_WALK_EN)
package ram8bit_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_WR   = 3'd1;
    localparam state_t S_RD   = 3'd2;
    localparam state_t S_WAIT = 3'd3;
    localparam state_t S_CMP  = 3'd4;
    localparam state_t S_DONE = 3'd5;

    localparam logic [7:0] PAT_ZERO = 8'h00;
    localparam logic [7:0] PAT_ONES = 8'hFF;
    localparam logic [7:0] PAT_55   = 8'h55;
    localparam logic [7:0] PAT_AA   = 8'hAA;

    localparam int BASE_PAT_CNT = 4;

`ifdef RAM8BIT_TESTER_WALK_EN
    localparam int PAT_CNT   = 12;
    localparam int PAT_IDX_W = 4;
`else
    localparam int PAT_CNT   = 4;
    localparam int PAT_IDX_W = 2;
`endif

    typedef logic [PAT_IDX_W-1:0] pat_idx_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ram8bit_pat_rom.sv
// rtl/ram8bit_pat_rom.sv - combinational pattern index to pattern value map (RAM8BIT_TESTER_WALK_EN)
module ram8bit_pat_rom
    import ram8bit_pkg::*;
(
    input  pat_idx_t   idx,
    output logic [7:0] pat
);

    always_comb begin
        pat = PAT_ZERO;
        case (idx)
            pat_idx_t'(0): pat = PAT_ZERO;
            pat_idx_t'(1): pat = PAT_ONES;
            pat_idx_t'(2): pat = PAT_55;
            pat_idx_t'(3): pat = PAT_AA;
`ifdef RAM8BIT_TESTER_WALK_EN
            // Indices past the base set walk a single one from bit 0 upward
            default:       pat = 8'h01 << (idx - pat_idx_t'(BASE_PAT_CNT));
`else
            default:       pat = PAT_ZERO;
`endif
        endcase
    end

endmodule

// File: rtl/ram8bit_tester.sv
// rtl/ram8bit_tester.sv - write/read/compare RAM pattern tester FSM with registered outputs (RAM8BIT_TESTER_WALK_EN)
module ram8bit_tester
    import ram8bit_pkg::*;
#(
    parameter int RD_LAT = 1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       wr_co,
    output logic       rd_co,
    output logic [7:0] data,
    input  logic [7:0] ram_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [7:0] fail_pat
);

    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    state_t     r_state;
    pat_idx_t   r_pat_idx;
    logic [1:0] r_wait_cnt;
    logic       r_wr_co;
    logic       r_rd_co;
    logic [7:0] r_data;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [7:0] r_err_cnt;
    logic [7:0] r_fail_pat;

    logic       w_in_run;
    logic       w_last_pat;
    logic       w_mismatch;
    logic [7:0] w_err_next;
    pat_idx_t   w_rom_idx;
    logic [7:0] w_rom_pat;

    // r_data still holds the pattern under test, so it doubles as the compare reference
    always_comb begin
        w_in_run   = (r_state == S_WR) || (r_state == S_RD) ||
                     (r_state == S_WAIT) || (r_state == S_CMP);
        w_last_pat = (r_pat_idx == pat_idx_t'(PAT_CNT - 1));
        w_mismatch = (r_state == S_CMP) && (ram_out != r_data);
        w_err_next = w_mismatch ? sat_inc8(r_err_cnt) : r_err_cnt;
        w_rom_idx  = (r_state == S_CMP) ? r_pat_idx + pat_idx_t'(1) : '0;
    end

    ram8bit_pat_rom u_pat_rom (
        .idx (w_rom_idx),
        .pat (w_rom_pat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pat_idx  <= '0;
            r_wait_cnt <= 2'd0;
            r_wr_co    <= 1'b0;
            r_rd_co    <= 1'b0;
            r_data     <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= 8'h00;
            r_fail_pat <= 8'h00;
        end else if (w_in_run && abort) begin
            // Abort wins over a same-cycle compare, which is therefore not counted
            r_state <= S_DONE;
            r_wr_co <= 1'b0;
            r_rd_co <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_WR;
                        r_pat_idx  <= '0;
                        r_wr_co    <= 1'b1;
                        r_data     <= w_rom_pat;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_err_cnt  <= 8'h00;
                        r_fail_pat <= 8'h00;
                    end
                end
                S_WR: begin
                    r_state <= S_RD;
                    r_wr_co <= 1'b0;
                    r_rd_co <= 1'b1;
                end
                S_RD: begin
                    r_state    <= S_WAIT;
                    r_rd_co    <= 1'b0;
                    r_wait_cnt <= WAIT_INIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        r_state <= S_CMP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                S_CMP: begin
                    r_err_cnt <= w_err_next;
                    if (w_mismatch && (r_err_cnt == 8'h00)) begin
                        r_fail_pat <= r_data;
                    end
                    if (w_last_pat) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 8'h00);
                    end else begin
                        r_state   <= S_WR;
                        r_pat_idx <= r_pat_idx + pat_idx_t'(1);
                        r_wr_co   <= 1'b1;
                        r_data    <= w_rom_pat;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_wr_co <= 1'b0;
                    r_rd_co <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_co    = r_wr_co;
    assign rd_co    = r_rd_co;
    assign data     = r_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign err_cnt  = r_err_cnt;
    assign fail_pat = r_fail_pat;

endmodule

// File: tb/tb_ram8bit_tester.sv
// tb/tb_ram8bit_tester.sv - randomized self-checking bench for ram8bit_tester against a pattern-list reference model (RAM8BIT_TESTER_WALK_EN)
module tb_ram8bit_tester;

    parameter int RD_LAT = 1;
    localparam int PER = 3 + RD_LAT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       wr_co;
    logic       rd_co;
    logic [7:0] data;
    logic [7:0] ram_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic [7:0] fail_pat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram8bit_tester #(.RD_LAT(RD_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .wr_co    (wr_co),
        .rd_co    (rd_co),
        .data     (data),
        .ram_out  (ram_out),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_pat (fail_pat)
    );

    // Single-location RAM with a configurable fault: stuck-at masks and optional inversion
    logic [7:0] f_and = 8'hFF;
    logic [7:0] f_or  = 8'h00;
    logic       f_inv = 1'b0;
    logic [7:0] mem   = 8'h00;
    logic [7:0] pipe [4] = '{default: 8'h00};

    always @(posedge clk) begin
        if (wr_co) mem <= ((data & f_and) | f_or) ^ {8{f_inv}};
        if (rd_co) pipe[0] <= mem;
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_out = pipe[RD_LAT-1];

    int wr_n = 0;
    int rd_n = 0;
    int both_n = 0;
    logic [7:0] wr_q [$];

    always @(negedge clk) begin
        if (wr_co) begin
            wr_n <= wr_n + 1;
            wr_q.push_back(data);
        end
        if (rd_co) rd_n <= rd_n + 1;
        if (wr_co && rd_co) both_n <= both_n + 1;
    end

    logic [7:0] pats [$];
    int npat;

    function automatic logic [7:0] ram_view(input logic [7:0] p);
        return ((p & f_and) | f_or) ^ {8{f_inv}};
    endfunction

    // Expected error count and first failing pattern over the first n patterns
    task automatic model(input int n, output int errs, output logic [7:0] fp);
        errs = 0;
        fp = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (ram_view(pats[i]) != pats[i]) begin
                if (errs == 0) fp = pats[i];
                errs = (errs < 255) ? errs + 1 : 255;
            end
        end
    endtask

    task automatic pulse_start_e0();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        n_checks++;
        if ({wr_co, rd_co, busy, done, pass} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 00000", {wr_co, rd_co, busy, done, pass});
        end
        n_checks++;
        if ({data, err_cnt, fail_pat} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 000000", {data, err_cnt, fail_pat});
        end
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b0;
        n_checks++;
        if ({busy, done, wr_co} !== 3'b0) begin
            n_fail++;
            $display("FAIL abort_in_idle: got %b want 000", {busy, done, wr_co});
        end
    endtask

    task automatic run_check(input string name, input logic [7:0] am, input logic [7:0] om,
                             input logic inv, input bit poke);
        int exp_err, n, w0, r0, b0;
        logic [7:0] exp_fp;
        logic busy_seen;
        int bad_idx;
        f_and = am; f_or = om; f_inv = inv;
        model(npat, exp_err, exp_fp);
        pulse_start_e0();
        w0 = wr_n; r0 = rd_n; b0 = both_n;
        busy_seen = busy;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            start = (poke && n == 3);
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        n_checks++;
        if (n != npat * PER) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles want %0d", name, n, npat * PER);
        end
        n_checks++;
        if (busy_seen !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy: got run=%b end=%b want 1/0", name, busy_seen, busy);
        end
        n_checks++;
        if (pass !== (exp_err == 0)) begin
            n_fail++;
            $display("FAIL %s pass: got %b want %b", name, pass, exp_err == 0);
        end
        n_checks++;
        if (err_cnt !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL %s err_cnt: got %0d want %0d", name, err_cnt, exp_err);
        end
        n_checks++;
        if (fail_pat !== exp_fp) begin
            n_fail++;
            $display("FAIL %s fail_pat: got %h want %h", name, fail_pat, exp_fp);
        end
        n_checks++;
        if (wr_n - w0 != npat || rd_n - r0 != npat || both_n != b0) begin
            n_fail++;
            $display("FAIL %s strobes: got wr=%0d rd=%0d both=%0d want %0d %0d 0",
                     name, wr_n - w0, rd_n - r0, both_n - b0, npat, npat);
        end
        bad_idx = -1;
        for (int i = 0; i < npat; i++)
            if (w0 + i >= wr_q.size() || (bad_idx < 0 && wr_q[w0 + i] !== pats[i])) bad_idx = i;
        n_checks++;
        if (bad_idx >= 0) begin
            n_fail++;
            $display("FAIL %s wr_order: index %0d got %h want %h", name, bad_idx,
                     (w0 + bad_idx < wr_q.size()) ? wr_q[w0 + bad_idx] : 8'hxx, pats[bad_idx]);
        end
    endtask

    task automatic test_abort(input string name, input int k, input int p,
                              input logic [7:0] am, input logic [7:0] om, input logic inv);
        int exp_err, w0, r0, w1, r1;
        logic [7:0] exp_fp;
        f_and = am; f_or = om; f_inv = inv;
        model(k, exp_err, exp_fp);
        pulse_start_e0();
        w0 = wr_n; r0 = rd_n;
        repeat (k * PER + p) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        n_checks++;
        if ({done, pass, busy, wr_co, rd_co} !== 5'b10000) begin
            n_fail++;
            $display("FAIL %s abort_state: got %b want 10000", name, {done, pass, busy, wr_co, rd_co});
        end
        n_checks++;
        if (err_cnt !== 8'(exp_err) || fail_pat !== exp_fp) begin
            n_fail++;
            $display("FAIL %s abort_err: got %0d/%h want %0d/%h", name, err_cnt, fail_pat, exp_err, exp_fp);
        end
        n_checks++;
        if (wr_n - w0 != k + 1 || rd_n - r0 != k + ((p >= 1) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s abort_strobes: got wr=%0d rd=%0d want %0d %0d", name,
                     wr_n - w0, rd_n - r0, k + 1, k + ((p >= 1) ? 1 : 0));
        end
        w1 = wr_n; r1 = rd_n;
        repeat (3 * PER) @(posedge clk);
        #1;
        n_checks++;
        if (wr_n != w1 || rd_n != r1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s post_abort: got wr+%0d rd+%0d done=%b want 0 0 1", name,
                     wr_n - w1, rd_n - r1, done);
        end
    endtask

    task automatic test_abort_in_done();
        run_check("ideal_pre_abort", 8'hFF, 8'h00, 1'b0, 1'b0);
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b0;
        n_checks++;
        if ({done, pass, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL abort_in_done: got %b want 110", {done, pass, busy});
        end
    endtask

    task automatic test_rst_mid(input int k);
        int w1, r1;
        f_and = 8'hFF; f_or = 8'h00; f_inv = 1'b0;
        pulse_start_e0();
        repeat (k * PER + 2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if ({wr_co, rd_co, busy, done, pass, data, err_cnt, fail_pat} !== 29'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got %b %h %h %h want all zero", {wr_co, rd_co, busy, done, pass},
                     data, err_cnt, fail_pat);
        end
        w1 = wr_n; r1 = rd_n;
        repeat (2 * PER) @(posedge clk);
        #1;
        n_checks++;
        if (wr_n != w1 || rd_n != r1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: got wr+%0d rd+%0d busy=%b want 0 0 0", wr_n - w1, rd_n - r1, busy);
        end
        run_check("after_rst", 8'hFF, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        pats = '{8'h00, 8'hFF, 8'h55, 8'hAA};
`ifdef RAM8BIT_TESTER_WALK_EN
        for (int i = 0; i < 8; i++) pats.push_back(8'h01 << i);
`endif
        npat = pats.size();

        test_reset();
        run_check("ideal", 8'hFF, 8'h00, 1'b0, 1'b0);
        run_check("stuck_bit0", 8'hFE, 8'h00, 1'b0, 1'b0);
        run_check("inverted_busy_start", 8'hFF, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++)
            run_check("random_fault", 8'($urandom), 8'($urandom) & 8'($urandom),
                      1'($urandom), 1'($urandom));
        test_abort("abort_rd_55", 2, 1, 8'hFE, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++)
            test_abort("abort_random", $urandom_range(0, npat - 1), $urandom_range(0, PER - 1),
                       8'($urandom), 8'h00, 1'b0);
        test_abort_in_done();
        test_rst_mid(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
